// File: rtl/mem_copy_client.sv
// Block copy engine: reads a run of 16-bit words into a local buffer through the
// memory read handshake, then writes them back out to RAM or DDR.
module mem_copy_client #(
    parameter int BUF_AW  = 6,
    parameter int TIMEOUT = 4095
) (
    input  logic        clk_150_0,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_src,
    input  logic        cmd_dst,
    input  logic [31:0] cmd_rd_addr,
    input  logic [31:0] cmd_wr_addr,
    input  logic [15:0] cmd_len,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_req_valid,
    output logic        mem_start,
    output logic        mem_read,
    output logic [1:0]  mem_read_source,
    input  logic        mem_read_ready,
    input  logic [15:0] mem_read_data,
    input  logic        mem_read_quit,
    output logic        mem_write,
    output logic        mem_write_source,
    output logic [15:0] mem_write_data,
    input  logic        mem_write_ddr_en,
    output logic [15:0] mem_pro_length,
    output logic [31:0] mem_rd_start_addr,
    output logic [31:0] mem_wr_start_addr
);

    localparam int          CW      = BUF_AW + 1;
    localparam int          WW      = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_LEN = 16'(2 ** BUF_AW);

    typedef enum logic [2:0] {IDLE, CLR, RD, WSTART, WR, FIN} state_t;

    state_t         state, state_n;
    logic [1:0]     src_q;
    logic           dst_q;
    logic [15:0]    len_q;
    logic [31:0]    rd_addr_q, wr_addr_q;
    logic [CW-1:0]  rcnt, wcnt, len_c;
    logic [WW-1:0]  wait_cnt;
    logic           wait_hit;
    logic           err_q;
    logic           accept, reject, abort, rd_take, wr_take;
    logic [15:0]    buf_mem [2**BUF_AW];

    // Length is validated at accept, so its low CW bits cover the whole range.
    assign len_c    = len_q[CW-1:0];
    assign wait_hit = (wait_cnt == WW'(TIMEOUT - 1));

    assign busy              = (state != IDLE);
    assign err               = err_q;
    assign mem_read_source   = src_q;
    assign mem_write_source  = dst_q;
    assign mem_pro_length    = len_q;
    assign mem_rd_start_addr = rd_addr_q;
    assign mem_wr_start_addr = wr_addr_q;
    assign mem_write_data    = mem_write ? buf_mem[wcnt[BUF_AW-1:0]] : '0;

    // Next-state and handshake decode; last ready/strobe moves on in the same cycle.
    always_comb begin
        state_n       = state;
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_start     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        done          = 1'b0;
        accept        = 1'b0;
        reject        = 1'b0;
        abort         = 1'b0;
        rd_take       = 1'b0;
        wr_take       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len == '0 || cmd_len > MAX_LEN || cmd_src == 2'b11)
                        reject = 1'b1;
                    else
                        state_n = CLR;
                end
            end
            CLR: begin
                mem_req_valid = 1'b1;
                mem_start     = 1'b1;
                state_n       = RD;
            end
            RD: begin
                if (rcnt < len_c) begin
                    mem_read = 1'b1;
                    if (mem_read_ready) begin
                        rd_take = 1'b1;
                        if (rcnt + CW'(1) == len_c)
                            state_n = WSTART;
                    end else if (mem_read_quit || wait_hit) begin
                        abort   = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    state_n = WSTART;
                end
            end
            WSTART: begin
                mem_start = 1'b1;
                state_n   = WR;
            end
            WR: begin
                if (wcnt < len_c) begin
                    if (dst_q || mem_write_ddr_en) begin
                        mem_write = 1'b1;
                        wr_take   = 1'b1;
                        if (wcnt + CW'(1) == len_c)
                            state_n = FIN;
                    end else if (wait_hit) begin
                        abort   = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    state_n = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, command latches, counters and the error pulse.
    always_ff @(posedge clk_150_0 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= 1'b0;
            len_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rcnt      <= '0;
            wcnt      <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= reject | abort;
            if (accept) begin
                src_q     <= cmd_src;
                dst_q     <= cmd_dst;
                len_q     <= cmd_len;
                rd_addr_q <= cmd_rd_addr;
                wr_addr_q <= cmd_wr_addr;
            end
            if (state == CLR)
                rcnt <= '0;
            else if (rd_take)
                rcnt <= rcnt + CW'(1);
            if (state == WSTART)
                wcnt <= '0;
            else if (wr_take)
                wcnt <= wcnt + CW'(1);
            if (state == CLR || state == WSTART || rd_take || wr_take)
                wait_cnt <= '0;
            else if (state == RD || state == WR)
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Local word buffer; read and write phases never overlap.
    always_ff @(posedge clk_150_0) begin
        if (rd_take)
            buf_mem[rcnt[BUF_AW-1:0]] <= mem_read_data;
    end

endmodule

// File: tb/tb_mem_copy_client.sv
// Directed bench for mem_copy_client: a command table run against a small
// reactive memory model, plus hand-written reset sequences.
module tb_mem_copy_client;

    localparam int BUF_AW  = 6;
    localparam int TIMEOUT = 4095;

    logic        clk_150_0 = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_dst;
    logic [1:0]  cmd_src;
    logic [31:0] cmd_rd_addr, cmd_wr_addr;
    logic [15:0] cmd_len;
    logic        done, err, busy, mem_req_valid, mem_start, mem_read;
    logic [1:0]  mem_read_source;
    logic        mem_read_ready, mem_read_quit, mem_write, mem_write_source, mem_write_ddr_en;
    logic [15:0] mem_read_data, mem_write_data, mem_pro_length;
    logic [31:0] mem_rd_start_addr, mem_wr_start_addr;

    always #5 clk_150_0 = ~clk_150_0;

    mem_copy_client #(.BUF_AW(BUF_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_150_0(clk_150_0), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_rd_addr(cmd_rd_addr), .cmd_wr_addr(cmd_wr_addr), .cmd_len(cmd_len),
        .done(done), .err(err), .busy(busy),
        .mem_req_valid(mem_req_valid), .mem_start(mem_start), .mem_read(mem_read),
        .mem_read_source(mem_read_source), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .mem_read_quit(mem_read_quit),
        .mem_write(mem_write), .mem_write_source(mem_write_source),
        .mem_write_data(mem_write_data), .mem_write_ddr_en(mem_write_ddr_en),
        .mem_pro_length(mem_pro_length), .mem_rd_start_addr(mem_rd_start_addr),
        .mem_wr_start_addr(mem_wr_start_addr)
    );

    typedef struct {
        logic [1:0]  src;
        logic        dst;
        logic [15:0] len;
        int          quit_after;   // assert read_quit once this many readies were given (0: never)
        int          no_ready;     // 1: memory never answers
        int          exp_done;
        int          exp_err;
        int          exp_writes;
        int          exp_starts;
        int          exp_err_cyc;  // cycle after accept edge where err shows, -1: never
    } vec_t;

    vec_t vecs[9];

    int checks = 0;
    int errors = 0;

    // Results of the last run_cmd
    int got_done, got_err, nstart, nreq, nwr, viol, data_bad, err_cyc, timed_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] src, input logic dst, input logic [15:0] len,
                                input int qa, input int nr, input int ed, input int ee,
                                input int ew, input int es, input int ec);
        vec_t v;
        v.src = src; v.dst = dst; v.len = len; v.quit_after = qa; v.no_ready = nr;
        v.exp_done = ed; v.exp_err = ee; v.exp_writes = ew; v.exp_starts = es; v.exp_err_cyc = ec;
        return v;
    endfunction

    // Word k served by the memory model: 0x1111, 0x2222, ... for the first words
    function automatic logic [15:0] word(input int k);
        return 16'((k + 1) * 32'h1111 + (k / 15) * 7);
    endfunction

    // Issue one command and play the memory side until done/err, a write count, or a cycle budget.
    task automatic run_cmd(input vec_t v, input int idx, input int stop_after_wr);
        int g, nrd, cyc;
        bit fin;
        got_done = 0; got_err = 0; nstart = 0; nreq = 0; nwr = 0; viol = 0; data_bad = 0;
        err_cyc = -1; g = 0; nrd = 0; cyc = 0; fin = 0;
        @(posedge clk_150_0); #1;
        cmd_valid   = 1'b1;
        cmd_src     = v.src;
        cmd_dst     = v.dst;
        cmd_len     = v.len;
        cmd_rd_addr = 32'h1000_0000 + 32'(idx);
        cmd_wr_addr = 32'h2000_0000 + 32'(idx);
        @(posedge clk_150_0); #1;
        cmd_valid = 1'b0;
        while (!fin && cyc < 6000) begin
            mem_read_ready   = 1'b0;
            mem_read_quit    = 1'b0;
            mem_read_data    = '0;
            mem_write_ddr_en = ~mem_write_ddr_en;
            if (mem_read && v.no_ready == 0) begin
                g++;
                if (g == 3) begin
                    g = 0;
                    mem_read_ready = 1'b1;
                    mem_read_data  = word(nrd);
                    nrd++;
                end else if (v.quit_after != 0 && nrd == v.quit_after) begin
                    mem_read_quit = 1'b1;
                end
            end
            @(negedge clk_150_0);
            cyc++;
            if (mem_start) nstart++;
            if (mem_req_valid) nreq++;
            if (mem_read && mem_write) viol++;
            if (mem_start && (mem_read || mem_write)) viol++;
            if (mem_write) begin
                if (!v.dst && !mem_write_ddr_en) viol++;
                if (mem_write_data !== word(nwr)) data_bad++;
                nwr++;
            end
            if (done) begin got_done++; fin = 1; end
            if (err) begin got_err++; err_cyc = cyc; fin = 1; end
            if (stop_after_wr != 0 && nwr == stop_after_wr) fin = 1;
            if (!fin) begin @(posedge clk_150_0); #1; end
        end
        timed_out = fin ? 0 : 1;
        mem_read_ready = 1'b0;
        mem_read_quit  = 1'b0;
    endtask

    initial begin
        vecs[0] = mk(2'b01, 1'b1, 16'd4,  0, 0, 1, 0, 4,  2, -1);   // ram -> ram
        vecs[1] = mk(2'b10, 1'b0, 16'd3,  0, 0, 1, 0, 3,  2, -1);   // ad -> ddr, en toggling
        vecs[2] = mk(2'b01, 1'b1, 16'd0,  0, 0, 0, 1, 0,  0, 1);    // zero length
        vecs[3] = mk(2'b01, 1'b1, 16'd65, 0, 0, 0, 1, 0,  0, 1);    // one past capacity
        vecs[4] = mk(2'b11, 1'b1, 16'd4,  0, 0, 0, 1, 0,  0, 1);    // illegal source
        vecs[5] = mk(2'b00, 1'b1, 16'd8,  5, 0, 0, 1, 0,  1, 18);   // quit after 5 readies
        vecs[6] = mk(2'b00, 1'b0, 16'd64, 0, 0, 1, 0, 64, 2, -1);   // full buffer, ddr -> ddr
        vecs[7] = mk(2'b10, 1'b0, 16'd1,  0, 0, 1, 0, 1,  2, -1);   // single word
        vecs[8] = mk(2'b01, 1'b1, 16'd2,  0, 1, 0, 1, 0,  1, TIMEOUT + 2); // read timeout

        reset = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = 1'b0; cmd_len = '0;
        cmd_rd_addr = '0; cmd_wr_addr = '0; mem_read_ready = 1'b0; mem_read_data = '0;
        mem_read_quit = 1'b0; mem_write_ddr_en = 1'b0;

        repeat (2) @(negedge clk_150_0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_read_write_start", {mem_read, mem_write, mem_start, mem_req_valid}, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_len", mem_pro_length, 0);
        check("rst_rd_addr", mem_rd_start_addr, 0);
        check("rst_wdata", mem_write_data, 0);
        @(posedge clk_150_0); #1;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i], i, 0);
            check($sformatf("v%0d_finished", i), timed_out, 0);
            check($sformatf("v%0d_done", i), got_done, vecs[i].exp_done);
            check($sformatf("v%0d_err", i), got_err, vecs[i].exp_err);
            check($sformatf("v%0d_err_cycle", i), err_cyc, vecs[i].exp_err_cyc);
            check($sformatf("v%0d_writes", i), nwr, vecs[i].exp_writes);
            check($sformatf("v%0d_starts", i), nstart, vecs[i].exp_starts);
            check($sformatf("v%0d_req_valid", i), nreq, (vecs[i].exp_starts > 0) ? 1 : 0);
            check($sformatf("v%0d_wdata", i), data_bad, 0);
            check($sformatf("v%0d_exclusive", i), viol, 0);
            check($sformatf("v%0d_len_latch", i), mem_pro_length, vecs[i].len);
            check($sformatf("v%0d_src_dst_latch", i), {mem_read_source, mem_write_source},
                  {vecs[i].src, vecs[i].dst});
            check($sformatf("v%0d_rd_addr", i), mem_rd_start_addr, 32'h1000_0000 + 32'(i));
            check($sformatf("v%0d_wr_addr", i), mem_wr_start_addr, 32'h2000_0000 + 32'(i));
            @(negedge clk_150_0);
            check($sformatf("v%0d_idle_after", i), {cmd_ready, busy, done, err, mem_read, mem_write},
                  6'b100000);
        end

        // Reset in the middle of the write phase of a 16-word copy
        begin
            vec_t rv;
            int stray;
            rv = mk(2'b01, 1'b1, 16'd16, 0, 0, 1, 0, 16, 2, -1);
            run_cmd(rv, 20, 5);
            check("midwr_reached", nwr, 5);
            check("midwr_writing", {busy, mem_write}, 2'b11);
            @(posedge clk_150_0); #1;
            reset = 1'b0;
            #1;
            check("midwr_rst_outputs", {mem_write, mem_read, mem_start, busy, done, err}, 0);
            check("midwr_rst_ready", cmd_ready, 1);
            check("midwr_rst_len", mem_pro_length, 0);
            stray = 0;
            repeat (3) begin
                @(negedge clk_150_0);
                if (done || err || mem_write) stray++;
            end
            check("midwr_no_pulse", stray, 0);
            @(posedge clk_150_0); #1;
            reset = 1'b1;
            run_cmd(vecs[0], 21, 0);
            check("after_rst_done", got_done, 1);
            check("after_rst_writes", nwr, 4);
            check("after_rst_wdata", data_bad, 0);
            check("after_rst_err", got_err, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
